mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between NUM_CORES core requesters using round-robin arbitration.
- Each core presents one request at a time (address, write enable, write data). The arbiter serialises these onto the memory's addr / read_en / write_en / write_val / read_val interface and returns read data with a one-cycle acknowledge.
- Sits in Processor between the cores' data-memory interfaces and the shared memory instance.

Parameters:
- MEM_WIDTH, 32, data word width in bits.
- MEM_SIZE, 256, memory depth in words; used for the address range check.
- NUM_CORES, 2, number of requesters; minimum 1, maximum 8.
- ADDR_WIDTH, 32, byte-address width.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req  in  NUM_CORES  per-core request level.
- we  in  NUM_CORES  per-core write enable (1 = write, 0 = read); qualified by req.
- addr  in  NUM_CORES*ADDR_WIDTH  per-core byte address, flattened; core i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- wdata  in  NUM_CORES*MEM_WIDTH  per-core write data, flattened the same way.
- ack  out  NUM_CORES  one-cycle completion pulse to the granted core.
- rdata  out  MEM_WIDTH  read data; valid only while some ack bit is high.
- err  out  1  one-cycle pulse, coincident with ack, for an out-of-range access.
- busy  out  1  high whenever the state is not IDLE.
- mem_addr  out  ADDR_WIDTH  address to memory.
- mem_read_en  out  1  memory read strobe.
- mem_write_en  out  1  memory write strobe.
- mem_write_val  out  MEM_WIDTH  memory write data.
- mem_read_val  in  MEM_WIDTH  memory read data; registered memory, valid one cycle after the mem_read_en cycle.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; ack=0, err=0, busy=0, rdata=0, mem_addr=0, mem_read_en=0, mem_write_en=0, mem_write_val=0; last_grant=NUM_CORES-1, so core 0 wins first.
- Reset asserted mid-access aborts the access: no ack is issued and any pending strobe drops immediately.
- Handshake: a core raises req with we/addr/wdata and holds all of them stable until it sees ack. It may keep req high after ack to issue a back-to-back request with new values.
- In any cycle where ack[i]=1, req[i] is masked from arbitration. This prevents double-granting the request that has just completed.
- State IDLE:
  - If any unmasked req bit is set, select the winner as the first set index scanning last_grant+1, last_grant+2, … modulo NUM_CORES.
  - Latch the winner's index, we, addr and wdata; set last_grant to the winner index.
  - Next state is ISSUE if the address is in range, otherwise ERR.
  - With no request, remain in IDLE.
- Range check: addr[ADDR_WIDTH-1:2] >= MEM_SIZE means out of range. addr[1:0] is ignored (word access only).
- State ISSUE, exactly one cycle:
  - mem_addr = latched address.
  - mem_read_en = !we_latched; mem_write_en = we_latched.
  - mem_write_val = wdata_latched.
  - Next state: CAPTURE.
- State CAPTURE, one cycle:
  - Both strobes are 0.
  - At the end of the cycle, register rdata = mem_read_val for reads, or 0 for writes.
  - Register ack[idx]=1 for the following cycle; next state: IDLE.
- State ERR, one cycle:
  - Both strobes are 0.
  - Register ack[idx]=1, err=1 and rdata=0 for the following cycle; next state: IDLE.
  - Memory is never touched on an out-of-range access.
- Latency:
  - If req is sampled in IDLE at edge k, ack is high during cycle k+3 for an in-range access and during cycle k+2 for an error.
  - Sustained throughput is one access per 3 cycles.
- ack, err and rdata are registered outputs.
- Simultaneous requests are resolved purely by round-robin. A core that is continuously requesting is granted at least once every NUM_CORES accesses, so no requester can starve.
- The arbiter never drives mem_read_en and mem_write_en high in the same cycle.

Decomposition:
- Shared package/defines:
  - State encoding: ARB_IDLE=2'd0, ARB_ISSUE=2'd1, ARB_CAPTURE=2'd2, ARB_ERR=2'd3.
  - The word-address shift constant (2).
- Sub-module rr_pick: combinational; inputs req_masked[N] and last_grant; outputs a found flag and the winner index. It is reusable later for the instruction-port arbiter.

Test Plan:
- Single read: core0 reads addr 0x10 with mem[4]=0xDEADBEEF -> mem_read_en high for one cycle with mem_addr=0x10; ack=2'b01 and rdata=0xDEADBEEF three cycles after req sampled; err=0.
- Single write: core1 writes 0x12345678 to 0x20 -> one mem_write_en cycle with mem_write_val=0x12345678; ack=2'b10; a subsequent read by core0 of 0x20 returns 0x12345678.
- Contention: both cores hold req continuously from reset -> grant order 0,1,0,1, with each ack spaced 3 cycles apart and no double ack.
- Out of range: core0 reads 0x400 (word 256, MEM_SIZE=256) -> no memory strobe; ack=2'b01 with err=1 and rdata=0 two cycles after sampling.
- Back-to-back: core0 keeps req high, changing addr from 0x0 to 0x4 in its ack cycle -> the second access completes 3 cycles later, with no re-grant of the old address during the ack cycle.
- Mid-operation reset: reset pulled to 0 during ISSUE -> strobes drop immediately; after release no ack is issued, busy=0, and the next contention grants core 0 first.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the data-memory port arbiter and its
// round-robin picker.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_ISSUE   = 2'd1,
      ARB_CAPTURE = 2'd2,
      ARB_ERR     = 2'd3
   } arb_state_t;

   // Byte address to word address: the memory is word-addressed only.
   localparam int WORD_SHIFT = 2;

   // Width of a requester index; a single requester still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Scan distance of requester idx when the scan starts just after last.
   function automatic int rr_distance(input int idx, input int last, input int n);
      return (idx - last - 1 + n) % n;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side request/acknowledge bundle of the data-memory port arbiter.
// master = the cores, slave = the arbiter.
interface mem_port_arbiter_if #(
   parameter int NUM_CORES  = 2,
   parameter int MEM_WIDTH  = 32,
   parameter int ADDR_WIDTH = 32
);
   logic [NUM_CORES-1:0]            req;
   logic [NUM_CORES-1:0]            we;
   logic [NUM_CORES*ADDR_WIDTH-1:0] addr;
   logic [NUM_CORES*MEM_WIDTH-1:0]  wdata;
   logic [NUM_CORES-1:0]            ack;
   logic [MEM_WIDTH-1:0]            rdata;
   logic                            err;

   modport master (output req, we, addr, wdata, input ack, rdata, err);
   modport slave  (input req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first requester set in the
// order last_grant+1, last_grant+2, ... modulo N.
module mem_port_arbiter_rr_pick
   import mem_port_arbiter_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     req_masked,
   input  logic [IDX_W-1:0] last_grant,
   output logic             found,
   output logic [IDX_W-1:0] winner
);

   int best_dist;

   // Keep the requester with the smallest scan distance from last_grant.
   // NOTE: every output of an always_comb gets a default first; a path that skips an assignment would otherwise infer a latch.
   always_comb begin
      found     = 1'b0;
      winner    = '0;
      best_dist = N;
      for (int i = 0; i < N; i++) begin
         if (req_masked[i] && (rr_distance(i, int'(last_grant), N) < best_dist)) begin
            found     = 1'b1;
            winner    = IDX_W'(i);
            best_dist = rr_distance(i, int'(last_grant), N);
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one registered data-memory port between
// NUM_CORES requesters. Each access runs IDLE -> ISSUE -> CAPTURE (or
// IDLE -> ERR when out of range) and completes with a one-cycle ack.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MEM_WIDTH  = 32,
   parameter int MEM_SIZE   = 256,
   parameter int NUM_CORES  = 2,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   mem_port_arbiter_if.slave     bus,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_read_en,
   output logic                  mem_write_en,
   output logic [MEM_WIDTH-1:0]  mem_write_val,
   input  logic [MEM_WIDTH-1:0]  mem_read_val
);

   localparam int IDX_W = idx_width(NUM_CORES);

   arb_state_t              state;
   logic [IDX_W-1:0]        last_grant;
   logic [IDX_W-1:0]        idx_q;
   logic                    we_q;

   logic [NUM_CORES-1:0]    req_masked;
   logic                    found;
   logic [IDX_W-1:0]        winner;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [MEM_WIDTH-1:0]    sel_wdata;
   logic                    sel_we;
   logic                    sel_in_range;

   // A core whose ack is high this cycle is still presenting the request
   // that just completed, so it sits out this arbitration round.
   assign req_masked = bus.req & ~bus.ack;

   mem_port_arbiter_rr_pick #(.N(NUM_CORES), .IDX_W(IDX_W)) u_rr_pick (
      .req_masked (req_masked),
      .last_grant (last_grant),
      .found      (found),
      .winner     (winner)
   );

   // Route the winning core's request fields to the latch inputs.
   always_comb begin
      sel_addr  = bus.addr[ADDR_WIDTH-1:0];
      sel_wdata = bus.wdata[MEM_WIDTH-1:0];
      sel_we    = bus.we[0];
      for (int i = 0; i < NUM_CORES; i++) begin
         if (winner == IDX_W'(i)) begin
            sel_addr  = bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = bus.wdata[i*MEM_WIDTH +: MEM_WIDTH];
            sel_we    = bus.we[i];
         end
      end
   end

   // Word index must lie inside the memory; the byte offset bits are ignored.
   assign sel_in_range = (sel_addr >> WORD_SHIFT) < ADDR_WIDTH'(MEM_SIZE);

   assign busy = (state != ARB_IDLE);

   // Arbitration FSM with registered memory strobes and core responses.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= ARB_IDLE;
         last_grant    <= IDX_W'(NUM_CORES - 1);
         idx_q         <= '0;
         we_q          <= 1'b0;
         bus.ack       <= '0;
         bus.err       <= 1'b0;
         bus.rdata     <= '0;
         mem_addr      <= '0;
         mem_read_en   <= 1'b0;
         mem_write_en  <= 1'b0;
         mem_write_val <= '0;
      end else begin
         bus.ack      <= '0;
         bus.err      <= 1'b0;
         mem_read_en  <= 1'b0;
         mem_write_en <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (found) begin
                  idx_q      <= winner;
                  last_grant <= winner;
                  we_q       <= sel_we;
                  if (sel_in_range) begin
                     // Strobes are registered, so they are high during ISSUE.
                     mem_addr      <= sel_addr;
                     mem_write_val <= sel_wdata;
                     mem_read_en   <= !sel_we;
                     mem_write_en  <= sel_we;
                     state         <= ARB_ISSUE;
                  end else begin
                     state <= ARB_ERR;
                  end
               end
            end
            ARB_ISSUE: begin
               state <= ARB_CAPTURE;
            end
            ARB_CAPTURE: begin
               bus.rdata <= we_q ? '0 : mem_read_val;
               bus.ack   <= NUM_CORES'(1) << idx_q;
               state     <= ARB_IDLE;
            end
            ARB_ERR: begin
               bus.rdata <= '0;
               bus.ack   <= NUM_CORES'(1) << idx_q;
               bus.err   <= 1'b1;
               state     <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a registered memory, a cycle-indexed
// expectation model driven by the arbitration rules, a per-cycle compare
// process and hand-computed checks for each scenario.
module tb_mem_port_arbiter;

   localparam int NC   = 2;
   localparam int MW   = 32;
   localparam int AW   = 32;
   localparam int MSZ  = 256;
   localparam int MAXC = 400;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          busy;
   logic [AW-1:0] mem_addr;
   logic          mem_read_en;
   logic          mem_write_en;
   logic [MW-1:0] mem_write_val;
   logic [MW-1:0] mem_read_val;

   mem_port_arbiter_if #(.NUM_CORES(NC), .MEM_WIDTH(MW), .ADDR_WIDTH(AW)) bus ();

   mem_port_arbiter #(
      .MEM_WIDTH(MW), .MEM_SIZE(MSZ), .NUM_CORES(NC), .ADDR_WIDTH(AW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .busy          (busy),
      .mem_addr      (mem_addr),
      .mem_read_en   (mem_read_en),
      .mem_write_en  (mem_write_en),
      .mem_write_val (mem_write_val),
      .mem_read_val  (mem_read_val)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input int i);
      case (i)
         0:       return 32'hA0A0_0000;
         1:       return 32'h1111_2222;
         4:       return 32'hDEAD_BEEF;
         default: return (32'(i) * 32'h0101_0101) ^ 32'h5A5A_5A5A;
      endcase
   endfunction

   // Registered single-port memory seen by the arbiter.
   logic [31:0] mem [MSZ];
   logic        mem_loaded = 1'b0;
   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < MSZ; i++) mem[i] <= init_word(i);
         mem_loaded <= 1'b1;
      end else begin
         if (mem_write_en) mem[mem_addr[9:2]] <= mem_write_val;
         if (mem_read_en)  mem_read_val <= mem[mem_addr[9:2]];
      end
   end

   // Expectations indexed by cycle number (cycle n lies between posedge n and n+1).
   logic [NC-1:0] exp_ack   [MAXC];
   logic          exp_err   [MAXC];
   logic          exp_rd    [MAXC];
   logic          exp_wr    [MAXC];
   logic          exp_busy  [MAXC];
   logic [31:0]   exp_rdata [MAXC];
   logic [31:0]   exp_maddr [MAXC];
   logic [31:0]   exp_wval  [MAXC];
   logic [31:0]   model_mem [MSZ];
   logic          model_loaded = 1'b0;
   int            last_g  = NC - 1;
   int            free_at = 0;
   int            m_c;
   int            m_w;
   logic [NC-1:0] m_masked;
   logic [31:0]   m_a;
   logic [31:0]   m_d;
   logic          m_we;

   // Model: at the edge ending cycle c, an idle arbiter grants the next
   // round-robin requester; strobe in c+1, ack in c+3 (error: ack in c+2).
   always @(posedge clk) begin
      m_c = cyc;
      if (!model_loaded) begin
         for (int i = 0; i < MSZ; i++) model_mem[i] = init_word(i);
         model_loaded = 1'b1;
      end
      if (!reset) begin
         for (int k = m_c; k < MAXC; k++) begin
            exp_ack[k] = '0; exp_err[k] = 1'b0; exp_rd[k] = 1'b0; exp_wr[k] = 1'b0;
            exp_busy[k] = 1'b0; exp_rdata[k] = '0; exp_maddr[k] = '0; exp_wval[k] = '0;
         end
         last_g  = NC - 1;
         free_at = 0;
      end else if (m_c + 3 < MAXC) begin
         m_masked = bus.req & ~exp_ack[m_c];
         if (m_c >= free_at && m_masked != '0) begin
            m_w = -1;
            for (int off = 1; off <= NC; off++)
               for (int i = 0; i < NC; i++)
                  if (m_w < 0 && i == (last_g + off) % NC && m_masked[i]) m_w = i;
            for (int i = 0; i < NC; i++)
               if (i == m_w) begin
                  m_a  = bus.addr[i*AW +: AW];
                  m_d  = bus.wdata[i*MW +: MW];
                  m_we = bus.we[i];
               end
            last_g = m_w;
            if ((m_a / 4) >= 32'(MSZ)) begin
               exp_busy[m_c+1]  = 1'b1;
               exp_ack[m_c+2]   = NC'(1 << m_w);
               exp_err[m_c+2]   = 1'b1;
               exp_rdata[m_c+2] = '0;
               free_at = m_c + 2;
            end else begin
               exp_busy[m_c+1]  = 1'b1;
               exp_busy[m_c+2]  = 1'b1;
               exp_maddr[m_c+1] = m_a;
               if (m_we) begin
                  exp_wr[m_c+1]   = 1'b1;
                  exp_wval[m_c+1] = m_d;
                  model_mem[m_a / 4] = m_d;
                  exp_rdata[m_c+3] = '0;
               end else begin
                  exp_rd[m_c+1]    = 1'b1;
                  exp_rdata[m_c+3] = model_mem[m_a / 4];
               end
               exp_ack[m_c+3] = NC'(1 << m_w);
               free_at = m_c + 3;
            end
         end
      end
      cyc = cyc + 1;
   end

   // Compare every cycle, mid-cycle on the falling edge.
   always @(negedge clk) begin
      if (cyc < MAXC) begin
         if (!reset) begin
            check($sformatf("rst_ack@%0d", cyc), bus.ack, 0);
            check($sformatf("rst_err@%0d", cyc), bus.err, 0);
            check($sformatf("rst_rdata@%0d", cyc), bus.rdata, 0);
            check($sformatf("rst_busy@%0d", cyc), busy, 0);
            check($sformatf("rst_strobes@%0d", cyc), {mem_read_en, mem_write_en}, 0);
            check($sformatf("rst_maddr@%0d", cyc), mem_addr, 0);
            check($sformatf("rst_wval@%0d", cyc), mem_write_val, 0);
         end else begin
            check($sformatf("cmp_ack@%0d", cyc), bus.ack, exp_ack[cyc]);
            check($sformatf("cmp_err@%0d", cyc), bus.err, exp_err[cyc]);
            check($sformatf("cmp_busy@%0d", cyc), busy, exp_busy[cyc]);
            check($sformatf("cmp_rd_en@%0d", cyc), mem_read_en, exp_rd[cyc]);
            check($sformatf("cmp_wr_en@%0d", cyc), mem_write_en, exp_wr[cyc]);
            if (exp_ack[cyc] != '0)
               check($sformatf("cmp_rdata@%0d", cyc), bus.rdata, exp_rdata[cyc]);
            if (exp_rd[cyc] || exp_wr[cyc])
               check($sformatf("cmp_maddr@%0d", cyc), mem_addr, exp_maddr[cyc]);
            if (exp_wr[cyc])
               check($sformatf("cmp_wval@%0d", cyc), mem_write_val, exp_wval[cyc]);
         end
      end
   end

   task automatic start_req(input int core, input logic w, input logic [31:0] a,
                            input logic [31:0] d, output int c);
      @(negedge clk);
      bus.we[core]             = w;
      bus.addr[core*AW +: AW]  = a;
      bus.wdata[core*MW +: MW] = d;
      bus.req[core]            = 1'b1;
      c = cyc;
   endtask

   task automatic wait_ack(output int at, output logic [NC-1:0] av,
                           output logic [31:0] rd, output logic e);
      at = -1; av = '0; rd = '0; e = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bus.ack != '0) begin
            at = cyc; av = bus.ack; rd = bus.rdata; e = bus.err;
            break;
         end
      end
      if (at < 0) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout: got no ack within 12 cycles, expected one");
      end
   endtask

   int            c0, c2, at, at2, first_at;
   logic [NC-1:0] av;
   logic [31:0]   rd;
   logic          e;

   initial begin
      bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_ack", bus.ack, 0);
      reset = 1'b1;

      // Single read, core 0, address 0x10 (word 4).
      start_req(0, 1'b0, 32'h10, 32'h0, c0);
      @(negedge clk);
      check("read_strobe", mem_read_en, 1);
      check("read_addr", mem_addr, 32'h10);
      wait_ack(at, av, rd, e);
      bus.req[0] = 1'b0;
      check("read_latency", at - c0, 3);
      check("read_ack", av, 2'b01);
      check("read_rdata", rd, 32'hDEAD_BEEF);
      check("read_err", e, 0);

      // Single write, core 1, then read it back from core 0.
      start_req(1, 1'b1, 32'h20, 32'h1234_5678, c0);
      @(negedge clk);
      check("write_strobe", mem_write_en, 1);
      check("write_val", mem_write_val, 32'h1234_5678);
      wait_ack(at, av, rd, e);
      bus.req[1] = 1'b0;
      check("write_ack", av, 2'b10);
      start_req(0, 1'b0, 32'h20, 32'h0, c0);
      wait_ack(at, av, rd, e);
      bus.req[0] = 1'b0;
      check("readback_rdata", rd, 32'h1234_5678);

      // Out of range: 0x400 is word 256.
      start_req(0, 1'b0, 32'h400, 32'h0, c0);
      @(negedge clk);
      check("oor_no_strobe", {mem_read_en, mem_write_en}, 2'b00);
      check("oor_busy", busy, 1);
      wait_ack(at, av, rd, e);
      bus.req[0] = 1'b0;
      check("oor_latency", at - c0, 2);
      check("oor_ack", av, 2'b01);
      check("oor_err", e, 1);
      check("oor_rdata", rd, 0);

      // Back-to-back: new address presented in the ack cycle.
      start_req(0, 1'b0, 32'h0, 32'h0, c0);
      wait_ack(at, av, rd, e);
      check("b2b_first_rdata", rd, 32'hA0A0_0000);
      bus.addr[0 +: AW] = 32'h4;
      c2 = cyc;
      wait_ack(at2, av, rd, e);
      bus.req[0] = 1'b0;
      // Masked in the ack cycle, sampled on the next edge, then 3 cycles.
      check("b2b_second_latency", at2 - c2, 4);
      check("b2b_second_ack", av, 2'b01);
      check("b2b_second_rdata", rd, 32'h1111_2222);

      // Reset during ISSUE aborts the access.
      start_req(0, 1'b0, 32'h10, 32'h0, c0);
      @(negedge clk);
      check("midrst_strobe_before", mem_read_en, 1);
      #1 reset = 1'b0;
      #1;
      check("midrst_strobe_drop", {mem_read_en, mem_write_en}, 2'b00);
      check("midrst_busy", busy, 0);
      bus.req = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("post_rst_no_ack", bus.ack, 0);
         check("post_rst_idle", busy, 0);
      end

      // Contention: both cores request continuously; core 0 goes first.
      @(negedge clk);
      bus.we = '0;
      bus.addr[0 +: AW] = 32'h8;
      bus.addr[AW +: AW] = 32'hC;
      bus.req = 2'b11;
      c0 = cyc;
      first_at = 0;
      for (int n = 0; n < 4; n++) begin
         wait_ack(at, av, rd, e);
         if (n == 3) bus.req = '0;
         if (n == 0) begin
            first_at = at;
            check("cont_first_latency", at - c0, 3);
         end else begin
            check($sformatf("cont_spacing_%0d", n), at - first_at, 3 * n);
         end
         check($sformatf("cont_order_%0d", n), av, (n % 2 == 0) ? 2'b01 : 2'b10);
         check($sformatf("cont_rdata_%0d", n), rd, (n % 2 == 0) ? 32'h5858_5858 : 32'h5959_5959);
      end

      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
